// File: rtl/fl_dist_pkg.sv
// Shared types and constant helpers for the FrameLink ticket distributor.
// Latency: none (types, constant functions and an elaboration check only).
// Backpressure: none.
//
// FL_DIST_CHECK is a generate-scope parameter guard, used by the distributor
// and reused by the sequencer bench so both sides reject the same configs.
`ifndef FL_DIST_PKG_SV
`define FL_DIST_PKG_SV

`define FL_DIST_CHECK(cond, msg) \
    if (!(cond)) begin : g_fl_dist_param_check \
        $error(msg); \
    end

package fl_dist_pkg;

    // Frame/part delimiters travel together as one field; all active-low.
    typedef struct packed {
        logic sof_n;
        logic eof_n;
        logic sop_n;
        logic eop_n;
    } delim_t;

    localparam delim_t DELIM_IDLE = '1;

    // Ceiling log2, never less than 1 so it is always usable as a width.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // The ticket field is a whole number of bytes.
    function automatic int ticket_bits(input int size_bytes);
        return size_bytes * 8;
    endfunction

endpackage

`endif

// File: rtl/fl_dist_out_reg.sv
// One-word holding register between the stamping mux and the output fan-out.
// Latency: 1 cycle from load to out_vld.
// Backpressure: holds its word until drain_rdy; a drain and a load may share a cycle.
//
// Ports: core_clk/rst (sync, active-high); load + in_* capture a word and its
// destination index; drain_rdy is the selected output's ready; out_* present it.
module fl_dist_out_reg
    import fl_dist_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DREM_WIDTH = 3,
    parameter int SEL_W      = 2
) (
    input  logic                  core_clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  drain_rdy,
    input  logic [DATA_WIDTH-1:0] in_dat,
    input  logic [DREM_WIDTH-1:0] in_rem,
    input  delim_t                in_delim,
    input  logic [SEL_W-1:0]      in_dst,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_dat,
    output logic [DREM_WIDTH-1:0] out_rem,
    output delim_t                out_delim,
    output logic [SEL_W-1:0]      out_dst
);

    // Load wins over drain: when both happen the old word leaves and the new
    // one takes its place, keeping the register full.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            out_vld <= 1'b0;
        end else if (load) begin
            out_vld <= 1'b1;
        end else if (drain_rdy) begin
            out_vld <= 1'b0;
        end
    end

    // Payload needs no reset: it is only visible while out_vld is set.
    always_ff @(posedge core_clk) begin
        if (load) begin
            out_dat   <= in_dat;
            out_rem   <= in_rem;
            out_delim <= in_delim;
            out_dst   <= in_dst;
        end
    end

endmodule

// File: rtl/fl_ticket_distributor.sv
// Round-robin FrameLink splitter: whole frames to OUTPUT_COUNT outputs, SOF word ticket-stamped.
// Latency: 1 cycle RX->TX; 1 word/cycle with no bubbles at frame boundaries.
// Backpressure: a stalled destination blocks the entire input (RX_DST_RDY_N comb from TX_DST_RDY_N[dst]).
//
// Ports: CLK, RESET (sync, active-high); RX_* single FrameLink input;
// TX_* OUTPUT_COUNT FrameLink outputs, slice/bit i belongs to output i.
module fl_ticket_distributor
    import fl_dist_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int DREM_WIDTH    = log2(DATA_WIDTH / 8),
    parameter int OUTPUT_COUNT  = 4,
    parameter int TICKET_OFFSET = 3,
    parameter int TICKET_SIZE   = 2
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [DATA_WIDTH-1:0]              RX_DATA,
    input  logic [DREM_WIDTH-1:0]              RX_REM,
    input  logic                               RX_SOF_N,
    input  logic                               RX_EOF_N,
    input  logic                               RX_SOP_N,
    input  logic                               RX_EOP_N,
    input  logic                               RX_SRC_RDY_N,
    output logic                               RX_DST_RDY_N,
    output logic [OUTPUT_COUNT*DATA_WIDTH-1:0] TX_DATA,
    output logic [OUTPUT_COUNT*DREM_WIDTH-1:0] TX_REM,
    output logic [OUTPUT_COUNT-1:0]            TX_SOF_N,
    output logic [OUTPUT_COUNT-1:0]            TX_EOF_N,
    output logic [OUTPUT_COUNT-1:0]            TX_SOP_N,
    output logic [OUTPUT_COUNT-1:0]            TX_EOP_N,
    output logic [OUTPUT_COUNT-1:0]            TX_SRC_RDY_N,
    input  logic [OUTPUT_COUNT-1:0]            TX_DST_RDY_N
);

    localparam int SEL_W      = log2(OUTPUT_COUNT);
    localparam int TICKET_W   = ticket_bits(TICKET_SIZE);
    localparam int TICKET_LSB = TICKET_OFFSET * 8;

    `FL_DIST_CHECK((TICKET_SIZE >= 1) && (TICKET_OFFSET >= 0) &&
                   (TICKET_OFFSET + TICKET_SIZE <= DATA_WIDTH / 8) &&
                   (OUTPUT_COUNT >= 2) && (OUTPUT_COUNT <= 8),
                   "fl_ticket_distributor: ticket field or output count out of range")

    logic [SEL_W-1:0]      sel;
    logic [TICKET_W-1:0]   ticket;
    logic                  rx_acc;
    logic [DATA_WIDTH-1:0] stamped_dat;
    delim_t                rx_delim;

    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_dat;
    logic [DREM_WIDTH-1:0] out_rem;
    delim_t                out_delim;
    logic [SEL_W-1:0]      out_dst;
    logic                  drain_rdy;

    assign rx_delim = '{sof_n: RX_SOF_N, eof_n: RX_EOF_N, sop_n: RX_SOP_N, eop_n: RX_EOP_N};

    // Ready only needs the held word's destination to be ready, so a word can
    // leave and the next arrive on the same edge.
    assign RX_DST_RDY_N = RESET | (out_vld & ~drain_rdy);
    assign rx_acc       = ~RX_SRC_RDY_N & ~RX_DST_RDY_N;

    // Ticket lands little-endian: its low byte goes to byte TICKET_OFFSET.
    always_comb begin
        stamped_dat = RX_DATA;
        if (!RX_SOF_N) begin
            stamped_dat[TICKET_LSB +: TICKET_W] = ticket;
        end
    end

    // Counters step on the EOF word only, so a frame never changes output
    // mid-way; an input missing its EOF simply keeps sel where it is.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel    <= '0;
            ticket <= '0;
        end else if (rx_acc && !RX_EOF_N) begin
            sel    <= (sel == SEL_W'(OUTPUT_COUNT - 1)) ? '0 : sel + SEL_W'(1);
            ticket <= ticket + TICKET_W'(1);
        end
    end

    fl_dist_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DREM_WIDTH (DREM_WIDTH),
        .SEL_W      (SEL_W)
    ) u_out_reg (
        .core_clk  (CLK),
        .rst       (RESET),
        .load      (rx_acc),
        .drain_rdy (drain_rdy),
        .in_dat    (stamped_dat),
        .in_rem    (RX_REM),
        .in_delim  (rx_delim),
        .in_dst    (sel),
        .out_vld   (out_vld),
        .out_dat   (out_dat),
        .out_rem   (out_rem),
        .out_delim (out_delim),
        .out_dst   (out_dst)
    );

    // Ready of the output currently holding the word; a loop rather than an
    // index keeps non-power-of-two OUTPUT_COUNT free of out-of-range reads.
    always_comb begin
        drain_rdy = 1'b0;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            if (out_vld && (out_dst == SEL_W'(i))) begin
                drain_rdy = ~TX_DST_RDY_N[i];
            end
        end
    end

    // Only the destination slice carries the word; idle slices are zero data
    // and deasserted delimiters.
    always_comb begin
        TX_DATA      = '0;
        TX_REM       = '0;
        TX_SOF_N     = '1;
        TX_EOF_N     = '1;
        TX_SOP_N     = '1;
        TX_EOP_N     = '1;
        TX_SRC_RDY_N = '1;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            if (out_vld && (out_dst == SEL_W'(i))) begin
                TX_DATA[i*DATA_WIDTH +: DATA_WIDTH] = out_dat;
                TX_REM[i*DREM_WIDTH +: DREM_WIDTH]  = out_rem;
                TX_SOF_N[i]     = out_delim.sof_n;
                TX_EOF_N[i]     = out_delim.eof_n;
                TX_SOP_N[i]     = out_delim.sop_n;
                TX_EOP_N[i]     = out_delim.eop_n;
                TX_SRC_RDY_N[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fl_ticket_distributor.sv
// Bench for fl_ticket_distributor: vector table + scoreboard on a 64b/4-output
// instance, and a ticket-wrap sweep on a 64b/3-output/1-byte-ticket instance.
// Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_fl_ticket_distributor;

    localparam int DW = 64;
    localparam int RW = 3;
    localparam int N  = 4;
    localparam int NB = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Primary DUT signals
    logic            RESET;
    logic [DW-1:0]   RX_DATA;
    logic [RW-1:0]   RX_REM;
    logic            RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N, RX_DST_RDY_N;
    logic [N*DW-1:0] TX_DATA;
    logic [N*RW-1:0] TX_REM;
    logic [N-1:0]    TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N, TX_DST_RDY_N;

    // Wrap DUT signals
    logic             b_reset;
    logic [DW-1:0]    b_rx_data;
    logic             b_rx_src_rdy_n, b_rx_dst_rdy_n;
    logic [NB*DW-1:0] b_tx_data;
    logic [NB*RW-1:0] b_tx_rem;
    logic [NB-1:0]    b_tx_sof_n, b_tx_eof_n, b_tx_sop_n, b_tx_eop_n, b_tx_src_rdy_n;
    logic [NB-1:0]    b_tx_dst_rdy_n;

    fl_ticket_distributor #(
        .DATA_WIDTH(DW), .DREM_WIDTH(RW), .OUTPUT_COUNT(N), .TICKET_OFFSET(3), .TICKET_SIZE(2)
    ) u_dut (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(RX_DATA), .RX_REM(RX_REM),
        .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N), .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N),
        .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
        .TX_DATA(TX_DATA), .TX_REM(TX_REM),
        .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N), .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N),
        .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N)
    );

    fl_ticket_distributor #(
        .DATA_WIDTH(DW), .DREM_WIDTH(RW), .OUTPUT_COUNT(NB), .TICKET_OFFSET(3), .TICKET_SIZE(1)
    ) u_dut_wrap (
        .CLK(CLK), .RESET(b_reset),
        .RX_DATA(b_rx_data), .RX_REM(3'd7),
        .RX_SOF_N(1'b0), .RX_EOF_N(1'b0), .RX_SOP_N(1'b0), .RX_EOP_N(1'b0),
        .RX_SRC_RDY_N(b_rx_src_rdy_n), .RX_DST_RDY_N(b_rx_dst_rdy_n),
        .TX_DATA(b_tx_data), .TX_REM(b_tx_rem),
        .TX_SOF_N(b_tx_sof_n), .TX_EOF_N(b_tx_eof_n), .TX_SOP_N(b_tx_sop_n), .TX_EOP_N(b_tx_eop_n),
        .TX_SRC_RDY_N(b_tx_src_rdy_n), .TX_DST_RDY_N(b_tx_dst_rdy_n)
    );

    int errors = 0;
    int checks = 0;
    int fidx   = 0;
    bit rnd_bp = 1'b0;

    typedef struct {
        int          port;
        logic [63:0] dat;
        logic [2:0]  rem;
        logic [3:0]  delim;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [63:0] dat;
        logic [2:0]  rem;
        logic        sof_n;
        logic        eof_n;
        int          port;
        logic [63:0] exp_dat;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [63:0] fd(input int f, input int w);
        return {8'hF0 ^ 8'(f), 8'(w), 48'hDEAD_BEEF_CAFE};
    endfunction

    function automatic logic [63:0] stamp16(input logic [63:0] d, input int t);
        logic [63:0] r;
        r = d;
        r[39:24] = t[15:0];
        return r;
    endfunction

    // Scoreboard: every transfer on any output must match the oldest expectation.
    always @(negedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (TX_SRC_RDY_N[i] === 1'b0 && TX_DST_RDY_N[i] === 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word port=%0d data=%h", i, TX_DATA[i*DW +: DW]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.port != i || TX_DATA[i*DW +: DW] !== e.dat || TX_REM[i*RW +: RW] !== e.rem ||
                        {TX_SOF_N[i], TX_EOF_N[i], TX_SOP_N[i], TX_EOP_N[i]} !== e.delim) begin
                        errors++;
                        $display("FAIL sb_word got port=%0d data=%h rem=%0d delim=%b want port=%0d data=%h rem=%0d delim=%b",
                                 i, TX_DATA[i*DW +: DW], TX_REM[i*RW +: RW],
                                 {TX_SOF_N[i], TX_EOF_N[i], TX_SOP_N[i], TX_EOP_N[i]},
                                 e.port, e.dat, e.rem, e.delim);
                    end
                end
                checks++;
                for (int j = 0; j < N; j++) begin
                    if (j != i && (TX_SRC_RDY_N[j] !== 1'b1 || TX_DATA[j*DW +: DW] !== '0 ||
                        TX_REM[j*RW +: RW] !== '0 ||
                        {TX_SOF_N[j], TX_EOF_N[j], TX_SOP_N[j], TX_EOP_N[j]} !== 4'hF)) begin
                        errors++;
                        $display("FAIL idle_slice port=%0d src_rdy_n=%b data=%h want 1/0", j,
                                 TX_SRC_RDY_N[j], TX_DATA[j*DW +: DW]);
                    end
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (rnd_bp) begin
            #1;
            TX_DST_RDY_N = 4'($urandom) & 4'($urandom);
        end
    end

    task automatic send_word(input logic [63:0] d, input logic [2:0] r, input logic sof_n,
                             input logic eof_n, input int port, input logic [63:0] exp_d);
        int   waits;
        exp_t e;
        waits = 0;
        RX_DATA = d; RX_REM = r;
        RX_SOF_N = sof_n; RX_SOP_N = sof_n; RX_EOF_N = eof_n; RX_EOP_N = eof_n;
        RX_SRC_RDY_N = 1'b0;
        forever begin
            @(negedge CLK);
            if (RX_DST_RDY_N === 1'b0) begin
                e.port = port; e.dat = exp_d; e.rem = r; e.delim = {sof_n, eof_n, sof_n, eof_n};
                sb.push_back(e);
                break;
            end
            waits++;
            if (waits > 200) begin
                checks++; errors++;
                $display("FAIL rx_accept_timeout rx_dst_rdy_n=%b after %0d cycles", RX_DST_RDY_N, waits);
                break;
            end
        end
        @(posedge CLK); #1;
        RX_SRC_RDY_N = 1'b1;
    endtask

    task automatic send_frame(input int len);
        int          p;
        logic [63:0] d;
        p = fidx % N;
        for (int w = 0; w < len; w++) begin
            d = fd(fidx, w);
            send_word(d, (w == len - 1) ? 3'(len) : 3'd7, (w == 0) ? 1'b0 : 1'b1,
                      (w == len - 1) ? 1'b0 : 1'b1, p, (w == 0) ? stamp16(d, fidx) : d);
        end
        fidx++;
    endtask

    task automatic do_reset();
        RESET = 1'b1; RX_SRC_RDY_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (RX_DST_RDY_N !== 1'b1) begin
            errors++; $display("FAIL rst_rx_rdy got %b want 1", RX_DST_RDY_N);
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++;
        if (TX_SRC_RDY_N !== 4'hF || TX_DATA !== '0 || TX_REM !== '0 || TX_SOF_N !== 4'hF ||
            TX_EOF_N !== 4'hF || TX_SOP_N !== 4'hF || TX_EOP_N !== 4'hF) begin
            errors++;
            $display("FAIL rst_tx_idle src_rdy_n=%b sof_n=%b eof_n=%b data_nz=%b want 1111/1111/1111/0",
                     TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, |TX_DATA);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        sb.delete();
        fidx = 0;
    endtask

    task automatic drain_check(input string name);
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL %s pending=%0d want 0", name, sb.size());
        end
    endtask

    task automatic stall_check(input logic [63:0] held);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            checks++;
            if (RX_DST_RDY_N !== 1'b1 || TX_SRC_RDY_N[1] !== 1'b0 || TX_DATA[127:64] !== held) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d rx_dst_rdy_n=%b src_rdy_n1=%b data=%h want 1/0/%h",
                         k, RX_DST_RDY_N, TX_SRC_RDY_N[1], TX_DATA[127:64], held);
            end
        end
        @(posedge CLK); #1;
        TX_DST_RDY_N = '0;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog simulation time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          p;
        logic [63:0] exp_d;
        logic [2:0]  exp_src;
        vec_t        v;

        RESET = 1'b1; RX_DATA = '0; RX_REM = '0;
        RX_SOF_N = 1'b1; RX_EOF_N = 1'b1; RX_SOP_N = 1'b1; RX_EOP_N = 1'b1;
        RX_SRC_RDY_N = 1'b1; TX_DST_RDY_N = '0;
        b_reset = 1'b1; b_rx_data = '0; b_rx_src_rdy_n = 1'b1; b_tx_dst_rdy_n = '0;
        @(posedge CLK); #1;
        do_reset();

        // Round-robin: eight 3-word frames, all outputs ready
        tbl.delete();
        for (int f = 0; f < 8; f++) begin
            for (int w = 0; w < 3; w++) begin
                v.dat = fd(f, w);
                v.rem = (w == 2) ? 3'(f) : 3'd7;
                v.sof_n = (w == 0) ? 1'b0 : 1'b1;
                v.eof_n = (w == 2) ? 1'b0 : 1'b1;
                v.port = f % N;
                v.exp_dat = (w == 0) ? stamp16(v.dat, f) : v.dat;
                tbl.push_back(v);
            end
        end
        t0 = cyc;
        foreach (tbl[i]) send_word(tbl[i].dat, tbl[i].rem, tbl[i].sof_n, tbl[i].eof_n, tbl[i].port, tbl[i].exp_dat);
        checks++;
        if (cyc - t0 != 24) begin
            errors++; $display("FAIL rr_no_idle cycles=%0d want 24", cyc - t0);
        end
        drain_check("rr_drain");

        // Single-word frames: tickets 0..4, output wraps to 0 on frame 4
        do_reset();
        tbl.delete();
        for (int f = 0; f < 5; f++) begin
            v.dat = fd(f + 16, 0);
            v.rem = 3'd5; v.sof_n = 1'b0; v.eof_n = 1'b0;
            v.port = f % N;
            v.exp_dat = stamp16(v.dat, f);
            tbl.push_back(v);
        end
        foreach (tbl[i]) send_word(tbl[i].dat, tbl[i].rem, tbl[i].sof_n, tbl[i].eof_n, tbl[i].port, tbl[i].exp_dat);
        drain_check("single_drain");

        // Backpressure: output 1 stalled for 10 cycles mid-frame
        do_reset();
        send_frame(1);
        send_word(fd(1, 0), 3'd7, 1'b0, 1'b1, 1, stamp16(fd(1, 0), 1));
        send_word(fd(1, 1), 3'd7, 1'b1, 1'b1, 1, fd(1, 1));
        TX_DST_RDY_N = 4'b0010;
        fork
            send_word(fd(1, 2), 3'd7, 1'b1, 1'b1, 1, fd(1, 2));
            stall_check(fd(1, 1));
        join
        send_word(fd(1, 3), 3'd7, 1'b1, 1'b1, 1, fd(1, 3));
        send_word(fd(1, 4), 3'd4, 1'b1, 1'b0, 1, fd(1, 4));
        fidx = 2;
        send_frame(2);
        drain_check("bp_drain");

        // Reset in the middle of a frame held on output 1
        do_reset();
        send_frame(1);
        send_word(fd(1, 0), 3'd7, 1'b0, 1'b1, 1, stamp16(fd(1, 0), 1));
        send_word(fd(1, 1), 3'd7, 1'b1, 1'b1, 1, fd(1, 1));
        TX_DST_RDY_N = 4'b0010;
        do_reset();
        TX_DST_RDY_N = '0;
        send_frame(3);
        drain_check("midrst_drain");

        // Random-length frames under random per-output backpressure
        do_reset();
        rnd_bp = 1'b1;
        for (int f = 0; f < 40; f++) send_frame($urandom_range(1, 6));
        rnd_bp = 1'b0;
        @(posedge CLK); #2;
        TX_DST_RDY_N = '0;
        drain_check("rand_drain");

        // Ticket wrap with 1-byte tickets and three outputs
        repeat (2) @(posedge CLK);
        #1;
        b_reset = 1'b0;
        for (int k = 0; k <= 258; k++) begin
            if (k < 258) begin
                b_rx_data = 64'h0123_4567_89AB_CDEF ^ 64'(k);
                b_rx_src_rdy_n = 1'b0;
            end else begin
                b_rx_src_rdy_n = 1'b1;
            end
            @(negedge CLK);
            if (k > 0) begin
                p = (k - 1) % NB;
                exp_d = 64'h0123_4567_89AB_CDEF ^ 64'(k - 1);
                exp_d[31:24] = 8'(k - 1);
                exp_src = 3'b111;
                exp_src[p] = 1'b0;
                checks++;
                if (b_tx_src_rdy_n !== exp_src || b_tx_data[p*DW +: DW] !== exp_d ||
                    (k < 258 && b_rx_dst_rdy_n !== 1'b0)) begin
                    errors++;
                    $display("FAIL wrap_word frame=%0d src_rdy_n=%b data=%h rx_dst_rdy_n=%b want %b/%h/0",
                             k - 1, b_tx_src_rdy_n, b_tx_data[p*DW +: DW], b_rx_dst_rdy_n, exp_src, exp_d);
                end
                if (k - 1 >= 255) begin
                    checks++;
                    if (b_tx_data[p*DW + 24 +: 8] !== ((k - 1 == 255) ? 8'hFF : (k - 1 == 256) ? 8'h00 : 8'h01)) begin
                        errors++;
                        $display("FAIL wrap_ticket frame=%0d got %h", k - 1, b_tx_data[p*DW + 24 +: 8]);
                    end
                end
            end
            @(posedge CLK); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
